regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (RD/WData/RegWr) between two writeback

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/regfile_wb_arbiter_wb_arb2.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Request bit positions and default widths used by the top, arbiter and interface.
package regfile_wb_arbiter_pkg;

    localparam int REQ_A  = 0;
    localparam int REQ_M  = 1;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_M = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU/load requests, hold, scoreboard issue/query and RegFile write port.
import regfile_wb_arbiter_pkg::*;

interface regfile_wb_arbiter_if #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          AValid;
    logic [AW-1:0] ARd;
    logic [DW-1:0] AData;
    logic          AReady;
    logic          MValid;
    logic [AW-1:0] MRd;
    logic [DW-1:0] MData;
    logic          MReady;
    logic          WbHold;
    logic          Issue;
    logic [AW-1:0] IssueRd;
    logic [AW-1:0] QRs1;
    logic [AW-1:0] QRs2;
    logic          Rs1Busy;
    logic          Rs2Busy;
    logic [AW-1:0] RD;
    logic [DW-1:0] WData;
    logic          RegWr;

    modport master (
        output AValid, ARd, AData, MValid, MRd, MData, WbHold,
               Issue, IssueRd, QRs1, QRs2,
        input  AReady, MReady, Rs1Busy, Rs2Busy, RD, WData, RegWr
    );

    modport slave (
        input  AValid, ARd, AData, MValid, MRd, MData, WbHold,
               Issue, IssueRd, QRs1, QRs2,
        output AReady, MReady, Rs1Busy, Rs2Busy, RD, WData, RegWr
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_arb2.sv
// Two-way grant between ALU and load writeback buffers.
// RR_ARB_EN selects round-robin; otherwise fixed priority with loads first.
import regfile_wb_arbiter_pkg::*;

module wb_arb2 (
`ifdef RR_ARB_EN
    input  logic       Clk,
    input  logic       Reset,
`endif
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] gnt
);

`ifdef RR_ARB_EN
    // prio_q names the source that wins the next collision.
    src_e prio_q, prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (!hold) begin
            if (req[REQ_A] && req[REQ_M]) begin
                if (prio_q == SRC_M) gnt[REQ_M] = 1'b1;
                else                 gnt[REQ_A] = 1'b1;
            end else begin
                gnt = req;
            end
        end
        if (gnt[REQ_A])      prio_d = SRC_M;
        else if (gnt[REQ_M]) prio_d = SRC_A;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) prio_q <= SRC_A;
        else       prio_q <= prio_d;
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (!hold) begin
            gnt[REQ_M] = req[REQ_M];
            gnt[REQ_A] = req[REQ_A] & ~req[REQ_M];
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegFile write port between ALU and load writeback, with skid buffers
// and a RAW busy scoreboard. Build option RR_ARB_EN enables round-robin arbitration.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_wb_arbiter_if.slave  wb
);
    localparam int NREG = 2 ** AW;

    logic          a_vld_q, a_vld_d, m_vld_q, m_vld_d;
    logic [AW-1:0] a_rd_q, a_rd_d, m_rd_q, m_rd_d;
    logic [DW-1:0] a_dat_q, a_dat_d, m_dat_q, m_dat_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic [NREG-1:0] sb_q, sb_d;
    logic [1:0]    req, gnt;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_dat;

    assign req[REQ_A] = a_vld_q;
    assign req[REQ_M] = m_vld_q;

    wb_arb2 u_arb (
`ifdef RR_ARB_EN
        .Clk   (Clk),
        .Reset (Reset),
`endif
        .req   (req),
        .hold  (wb.WbHold),
        .gnt   (gnt)
    );

    // A buffer slot frees up in the same cycle it is granted.
    assign wb.AReady = ~a_vld_q | gnt[REQ_A];
    assign wb.MReady = ~m_vld_q | gnt[REQ_M];

    assign sel_rd  = gnt[REQ_M] ? m_rd_q  : a_rd_q;
    assign sel_dat = gnt[REQ_M] ? m_dat_q : a_dat_q;

    always_comb begin
        a_vld_d = a_vld_q & ~gnt[REQ_A];
        a_rd_d  = a_rd_q;
        a_dat_d = a_dat_q;
        if (wb.AValid && wb.AReady) begin
            a_vld_d = 1'b1;
            a_rd_d  = wb.ARd;
            a_dat_d = wb.AData;
        end
        m_vld_d = m_vld_q & ~gnt[REQ_M];
        m_rd_d  = m_rd_q;
        m_dat_d = m_dat_q;
        if (wb.MValid && wb.MReady) begin
            m_vld_d = 1'b1;
            m_rd_d  = wb.MRd;
            m_dat_d = wb.MData;
        end
    end

    // A granted entry for x0 consumes its slot but produces no write.
    always_comb begin
        wr_d   = (|gnt) && (sel_rd != '0);
        rd_d   = rd_q;
        wdat_d = wdat_q;
        if (wr_d) begin
            rd_d   = sel_rd;
            wdat_d = sel_dat;
        end
    end

    // Clear runs before set so an issue to the retiring register keeps it busy.
    always_comb begin
        sb_d = sb_q;
        if (wr_q) sb_d[rd_q] = 1'b0;
        if (wb.Issue) sb_d[wb.IssueRd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_vld_q <= 1'b0;
            a_rd_q  <= '0;
            a_dat_q <= '0;
            m_vld_q <= 1'b0;
            m_rd_q  <= '0;
            m_dat_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= '0;
            wdat_q  <= '0;
            sb_q    <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            a_rd_q  <= a_rd_d;
            a_dat_q <= a_dat_d;
            m_vld_q <= m_vld_d;
            m_rd_q  <= m_rd_d;
            m_dat_q <= m_dat_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wdat_q  <= wdat_d;
            sb_q    <= sb_d;
        end
    end

    assign wb.Rs1Busy = sb_q[wb.QRs1];
    assign wb.Rs2Busy = sb_q[wb.QRs2];
    assign wb.RegWr   = wr_q;
    assign wb.RD      = rd_q;
    assign wb.WData   = wdat_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model. Define RR_ARB_EN to match a round-robin build.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .wb    (bus.slave)
    );

    // Reference model: pending writes per source, busy set, last write issued.
    ent_t          qa[$];
    ent_t          qm[$];
    bit            busy[32];
    bit            m_wr;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    int            last_win;
    int            checks = 0;
    int            errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qm.delete();
        foreach (busy[i]) busy[i] = 1'b0;
        m_wr     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
        last_win = 1;
    endtask

    task automatic idle_inputs();
        bus.AValid = 0; bus.ARd = '0; bus.AData = '0;
        bus.MValid = 0; bus.MRd = '0; bus.MData = '0;
        bus.WbHold = 0; bus.Issue = 0; bus.IssueRd = '0;
        bus.QRs1 = '0;  bus.QRs2 = '0;
    endtask

    // Called at a falling edge after inputs are set; checks, advances model, waits one cycle.
    task automatic step();
        int   win;
        bit   era, erm;
        ent_t e;
        #1;
        win = -1;
        if (!bus.WbHold) begin
            if (qa.size() > 0 && qm.size() > 0) begin
`ifdef RR_ARB_EN
                win = (last_win == 0) ? 1 : 0;
`else
                win = 1;
`endif
            end else if (qm.size() > 0) win = 1;
            else if (qa.size() > 0)     win = 0;
        end
        era = (qa.size() == 0) || (win == 0);
        erm = (qm.size() == 0) || (win == 1);
        check_eq("AReady",  bus.AReady,  era);
        check_eq("MReady",  bus.MReady,  erm);
        check_eq("Rs1Busy", bus.Rs1Busy, busy[bus.QRs1]);
        check_eq("Rs2Busy", bus.Rs2Busy, busy[bus.QRs2]);
        check_eq("RegWr",   bus.RegWr,   m_wr);
        if (m_wr) begin
            check_eq("RD",    bus.RD,    m_rd);
            check_eq("WData", bus.WData, m_data);
        end
        if (m_wr) busy[m_rd] = 1'b0;
        if (bus.Issue && bus.IssueRd != 0) busy[bus.IssueRd] = 1'b1;
        m_wr = 1'b0;
        if (win >= 0) begin
            e = (win == 1) ? qm.pop_front() : qa.pop_front();
            last_win = win;
            if (e.rd != 0) begin
                m_wr   = 1'b1;
                m_rd   = e.rd;
                m_data = e.data;
            end
        end
        if (bus.AValid && era) qa.push_back('{bus.ARd, bus.AData});
        if (bus.MValid && erm) qm.push_back('{bus.MRd, bus.MData});
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        check_eq("rst_RegWr", bus.RegWr, 0);
        check_eq("rst_RD",    bus.RD,    0);
        check_eq("rst_WData", bus.WData, 0);
        Reset = 1'b0;
        step();

        // Single ALU write
        bus.AValid = 1; bus.ARd = 5; bus.AData = 32'h1234;
        step();
        idle_inputs();
        repeat (3) step();

        // Collision between both sources
        bus.AValid = 1; bus.ARd = 3; bus.AData = 32'hA;
        bus.MValid = 1; bus.MRd = 4; bus.MData = 32'hB;
        step();
        idle_inputs();
        repeat (4) step();

        // Scoreboard: x7 busy through its write, x0 never busy
        bus.Issue = 1; bus.IssueRd = 7; bus.QRs1 = 7; bus.QRs2 = 0;
        step();
        bus.Issue = 1; bus.IssueRd = 0;
        bus.AValid = 1; bus.ARd = 7; bus.AData = 32'h77;
        step();
        bus.Issue = 0; bus.AValid = 0;
        repeat (4) step();

        // Same-edge set and clear of x9
        bus.Issue = 1; bus.IssueRd = 9; bus.QRs1 = 9;
        bus.AValid = 1; bus.ARd = 9; bus.AData = 32'h99;
        step();
        bus.Issue = 0; bus.AValid = 0;
        step();
        bus.Issue = 1; bus.IssueRd = 9;
        step();
        bus.Issue = 0;
        repeat (3) step();

        // Hold with both buffers full, then release
        idle_inputs();
        bus.WbHold = 1;
        bus.AValid = 1; bus.ARd = 12; bus.AData = 32'hC;
        bus.MValid = 1; bus.MRd = 13; bus.MData = 32'hD;
        step();
        bus.AValid = 0; bus.MValid = 0;
        repeat (3) step();
        bus.WbHold = 0;
        repeat (4) step();

        // Reset while a write is in flight and both buffers are full
        bus.Issue = 1; bus.IssueRd = 10; bus.QRs1 = 10; bus.QRs2 = 11;
        bus.AValid = 1; bus.ARd = 10; bus.AData = 32'h10;
        bus.MValid = 1; bus.MRd = 11; bus.MData = 32'h11;
        step();
        bus.Issue = 0;
        bus.ARd = 14; bus.AData = 32'h14;
        bus.MRd = 15; bus.MData = 32'h15;
        step();
        idle_inputs();
        check_eq("pre_rst_RegWr", bus.RegWr, 1);
        #2 Reset = 1'b1;
        #1;
        check_eq("mid_rst_RegWr", bus.RegWr, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        check_eq("post_rst_RD",    bus.RD,    0);
        check_eq("post_rst_WData", bus.WData, 0);
        for (int r = 0; r < 32; r += 2) begin
            bus.QRs1 = r[AW-1:0];
            bus.QRs2 = AW'(r + 1);
            step();
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bus.AValid  = $urandom_range(0, 1);
            bus.ARd     = AW'($urandom_range(0, 31));
            bus.AData   = $urandom;
            bus.MValid  = $urandom_range(0, 1);
            bus.MRd     = AW'($urandom_range(0, 31));
            bus.MData   = $urandom;
            bus.WbHold  = ($urandom_range(0, 4) == 0);
            bus.Issue   = $urandom_range(0, 1);
            bus.IssueRd = AW'($urandom_range(0, 7));
            bus.QRs1    = AW'($urandom_range(0, 7));
            bus.QRs2    = AW'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
